// File: rtl/pack_signed_serial_if.sv
// Purpose: handshake bundle for the byte-serial signed LEB128 encoder.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the value side, out_valid/out_ready on the byte side.
// Ports: in_data/in_valid/in_ready (value in), out_byte/out_valid/out_ready/out_last/out_idx (bytes out).
interface pack_signed_serial_if #(
    parameter int N = 64
);
    localparam int MB   = N / 7 + 1;
    localparam int IDXW = $clog2(MB);

    logic [N-1:0]    in_data;
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      out_byte;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic [IDXW-1:0] out_idx;

    // master: value producer and byte sink (the environment around the encoder)
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_byte, out_valid, out_last, out_idx
    );

    // slave: the encoder itself
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_byte, out_valid, out_last, out_idx
    );
endinterface

// File: rtl/pack_signed_serial.sv
// Purpose: byte-serial minimal signed LEB128 encoder, LS chunk first, with last flag and byte index.
// Latency: first byte valid the cycle after input acceptance; k-byte value takes k cycles at full rate.
// Backpressure: bytes hold while out_ready=0; next value accepted in IDLE or on the last-byte handshake.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries the value input and byte output channels.
module pack_signed_serial #(
    parameter int N = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    pack_signed_serial_if.slave  bus
);
    localparam int MB   = N / 7 + 1;
    localparam int IDXW = $clog2(MB);

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    sr;
    logic [IDXW-1:0] idx;
    logic            last;
    logic            in_hs;
    logic            byte_hs;

    // Remaining value fits in the current 7-bit chunk once everything from
    // bit 6 upward is pure sign: the chunk's bit 6 then carries the sign.
    assign last    = (&sr[N-1:6]) | ~(|sr[N-1:6]);
    assign in_hs   = bus.in_valid & bus.in_ready;
    assign byte_hs = (state == SEND) & bus.out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid) state_nxt = SEND;
            SEND: if (bus.out_ready && last) state_nxt = bus.in_valid ? SEND : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic. in_ready is the only output with a combinational input path
    // (from out_ready), which gives back-to-back values without a bubble.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_byte  = 8'h00;
        bus.out_last  = 1'b0;
        case (state)
            IDLE: bus.in_ready = 1'b1;
            SEND: begin
                bus.in_ready  = bus.out_ready & last;
                bus.out_valid = 1'b1;
                bus.out_byte  = {~last, sr[6:0]};
                bus.out_last  = last;
            end
            default: ;
        endcase
    end

    assign bus.out_idx = idx;

    // Shift register and byte index
    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            idx <= '0;
        end else if (in_hs) begin
            sr  <= bus.in_data;
            idx <= '0;
        end else if (byte_hs && !last) begin
            sr  <= {{7{sr[N-1]}}, sr[N-1:7]};
            idx <= idx + IDXW'(1);
        end
    end

    // By the final possible byte position the register is fully sign-filled.
    a_terminates: assert property (@(posedge clk) disable iff (rst)
        ((state == SEND) && (idx == IDXW'(MB - 1))) |-> last);

endmodule

// File: tb/tb_pack_signed_serial.sv
module tb_pack_signed_serial;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    pack_signed_serial_if #(.N(64)) bus ();

    pack_signed_serial #(.N(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Encode one value with out_ready held high. Expected bytes are packed
    // least-significant byte first: byte i = exp[8*i +: 8].
    task automatic encode(input string name, input logic [63:0] v, input int n, input logic [79:0] exp);
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_data   = v;
        bus.in_valid  = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle_in_ready got=%b want=1", name, bus.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 64'hDEAD_BEEF_CAFE_F00D;
        for (int i = 0; i < n; i++) begin
            #1;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_byte !== exp[8*i +: 8] ||
                bus.out_last !== (i == n - 1) || bus.out_idx !== 4'(i) ||
                bus.in_ready !== (i == n - 1)) begin
                n_fail++;
                $display("FAIL %s byte%0d got v=%b b=%h l=%b i=%0d r=%b want v=1 b=%h l=%b i=%0d r=%b",
                         name, i, bus.out_valid, bus.out_byte, bus.out_last, bus.out_idx, bus.in_ready,
                         exp[8*i +: 8], (i == n - 1), i, (i == n - 1));
            end
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_out_valid got=%b want=0", name, bus.out_valid);
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_byte !== 8'h00 || bus.out_last !== 1'b0 ||
            bus.out_idx !== 4'd0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state got v=%b b=%h l=%b i=%0d r=%b want v=0 b=00 l=0 i=0 r=1",
                     bus.out_valid, bus.out_byte, bus.out_last, bus.out_idx, bus.in_ready);
        end
    endtask

    task automatic test_small();
        encode("zero",   64'd0,            1, 80'h00);
        encode("minus1", 64'hFFFF_FFFF_FFFF_FFFF, 1, 80'h7F);
        encode("p63",    64'd63,           1, 80'h3F);
        encode("m64",    -64'sd64,         1, 80'h40);
    endtask

    task automatic test_sign_boundary();
        encode("p64",    64'd64,           2, 80'h00_C0);
        encode("m65",    -64'sd65,         2, 80'h7F_BF);
    endtask

    task automatic test_multi_byte();
        encode("p624485", 64'd624485,      3, 80'h26_8E_E5);
        encode("m123456", -64'sd123456,    3, 80'h78_BB_C0);
    endtask

    task automatic test_extremes();
        encode("min64", 64'h8000_0000_0000_0000, 10, 80'h7F_80_80_80_80_80_80_80_80_80);
        encode("max64", 64'h7FFF_FFFF_FFFF_FFFF, 10, 80'h00_FF_FF_FF_FF_FF_FF_FF_FF_FF);
    endtask

    // 624485 with a fixed stall pattern on out_ready; each observed byte must
    // still be the pending one, so a stalled byte that drifts is caught.
    task automatic test_stall();
        logic [15:0] pat;
        logic [7:0]  exp [3];
        int          k;
        int          cyc;
        pat    = 16'b1011_0010_0110_0100;
        exp[0] = 8'hE5;
        exp[1] = 8'h8E;
        exp[2] = 8'h26;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_data   = 64'd624485;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        k   = 0;
        cyc = 0;
        while (k < 3 && cyc < 60) begin
            bus.out_ready = pat[cyc % 16];
            #1;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_byte !== exp[k] || bus.out_idx !== 4'(k) ||
                bus.out_last !== (k == 2) || bus.in_ready !== (bus.out_ready & (k == 2))) begin
                n_fail++;
                $display("FAIL stall cyc%0d got v=%b b=%h i=%0d l=%b r=%b want v=1 b=%h i=%0d l=%b r=%b",
                         cyc, bus.out_valid, bus.out_byte, bus.out_idx, bus.out_last, bus.in_ready,
                         exp[k], k, (k == 2), (bus.out_ready & (k == 2)));
            end
            if (bus.out_ready) k++;
            cyc++;
            @(negedge clk);
        end
        n_checks++;
        if (k != 3) begin
            n_fail++;
            $display("FAIL stall_timeout got bytes=%0d want=3", k);
        end
        bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_done got out_valid=%b want=0", bus.out_valid);
        end
    endtask

    // in_valid held across values 1, -1, 300: one byte per cycle, no gaps.
    task automatic test_back_to_back();
        logic [63:0] vals [3];
        logic [7:0]  exp  [4];
        logic        lst  [4];
        int          vi;
        vals[0] = 64'd1;   vals[1] = 64'hFFFF_FFFF_FFFF_FFFF; vals[2] = 64'd300;
        exp[0] = 8'h01; exp[1] = 8'h7F; exp[2] = 8'hAC; exp[3] = 8'h02;
        lst[0] = 1'b1;  lst[1] = 1'b1;  lst[2] = 1'b0;  lst[3] = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_data   = vals[0];
        bus.in_valid  = 1'b1;
        vi = 1;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (vi < 3) begin
                bus.in_data  = vals[vi];
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_byte !== exp[k] || bus.out_last !== lst[k] ||
                bus.in_ready !== lst[k]) begin
                n_fail++;
                $display("FAIL b2b byte%0d got v=%b b=%h l=%b r=%b want v=1 b=%h l=%b r=%b",
                         k, bus.out_valid, bus.out_byte, bus.out_last, bus.in_ready, exp[k], lst[k], lst[k]);
            end
            if (bus.in_valid && bus.in_ready) vi++;
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || vi != 3) begin
            n_fail++;
            $display("FAIL b2b_done got out_valid=%b accepted=%0d want out_valid=0 accepted=3",
                     bus.out_valid, vi);
        end
    endtask

    // Reset after the second byte of 624485 has been taken.
    task automatic test_mid_reset();
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_data   = 64'd624485;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.out_byte !== 8'hE5) begin
            n_fail++;
            $display("FAIL mreset_b0 got=%h want=e5", bus.out_byte);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.out_byte !== 8'h8E || bus.out_idx !== 4'd1) begin
            n_fail++;
            $display("FAIL mreset_b1 got b=%h i=%0d want b=8e i=1", bus.out_byte, bus.out_idx);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL mreset_state got v=%b r=%b i=%0d want v=0 r=1 i=0",
                     bus.out_valid, bus.in_ready, bus.out_idx);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mreset_quiet got out_valid=%b want=0", bus.out_valid);
        end
        encode("after_reset_5", 64'd5, 1, 80'h05);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_small();
        test_sign_boundary();
        test_multi_byte();
        test_extremes();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule

// File: doc/pack_signed_serial.md
# pack_signed_serial

Byte-serial signed LEB128 encoder. Accepts one N-bit two's-complement value per transaction over a valid/ready input and emits its minimal signed LEB128 encoding one byte per cycle over a valid/ready output, with a last flag and byte index. It is the transmit-side counterpart of the team's parallel signed LEB128 unpacker, and feeds byte streams to serializers or packers.

## Interface

- N, 64, width of the signed input value; MB = N/7+1 is the maximum encoded length in bytes (10 for N=64).
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N  signed value to encode.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  encoder accepts in_data this cycle.
- out_byte  output  8  encoded byte: bit 7 is the continuation flag (1 = more bytes follow); bits 6:0 are the data chunk, least-significant chunk first.
- out_valid  output  1  out_byte is valid.
- out_ready  input  1  sink accepts out_byte this cycle.
- out_last  output  1  current byte is the final byte of the value; equals ~out_byte[7] whenever out_valid=1.
- out_idx  output  $clog2(MB)  zero-based index of the current byte within its value.

## Operation

- State: FSM {IDLE, SEND}, an N-bit shift register sr, and an out_idx counter.
- IDLE: in_ready=1 and out_valid=0. On in_valid & in_ready: sr <= in_data, out_idx <= 0, go to SEND.
- SEND: out_valid=1 and out_byte[6:0]=sr[6:0].
  - last = (sr[N-1:6] all zeros) | (sr[N-1:6] all ones).
  - out_byte[7] = ~last; out_last = last.
- Byte handshake (out_valid & out_ready) when not last: sr <= sr >>> 7 (arithmetic shift, sign fill), out_idx <= out_idx+1, stay in SEND.
- Byte handshake when last: the value is complete.
  - in_ready is asserted in this cycle, combinationally from out_ready.
  - If in_valid is also asserted: load the new value, out_idx <= 0, stay in SEND (back-to-back, no bubble).
  - Otherwise: go to IDLE.
- in_ready = IDLE | (SEND & out_ready & last). No other combinational input-to-output path exists; out_byte, out_valid, out_last and out_idx depend only on registers.
- Encoding is always minimal. Termination is guaranteed by out_idx = MB-1 because sr is fully sign-filled by then. If out_idx = MB-1 and last = 0, this is an assertion failure.
- Output stability: while out_valid=1 and out_ready=0, out_byte, out_last and out_idx hold constant.
- in_data is sampled only on the input handshake. Changes to in_data after acceptance have no effect.

## Timing

- Reset (rst=1 at an edge): FSM to IDLE, sr=0, out_idx=0.
  - Outputs after reset: out_valid=0, out_byte=0x00, out_last=0, out_idx=0, in_ready=1.
- Reset mid-message discards the remaining bytes. No further out_valid until a new input handshake.
- Latency: the first byte is valid in the cycle after input acceptance.
- A k-byte value occupies exactly k output cycles when out_ready is held at 1.
- Sustained throughput is one byte per cycle across value boundaries.
- While out_valid=0, out_byte and out_last are don't-care for the sink. The bench checks them only while out_valid=1.

## Test plan

- Small values, with out_ready=1:
  - 0 -> 0x00 (last, idx 0).
  - -1 -> 0x7F.
  - 63 -> 0x3F.
  - -64 -> 0x40.
- Sign-boundary values:
  - 64 -> 0xC0, 0x00.
  - -65 -> 0xBF, 0x7F.
  - out_idx steps 0,1 in both cases, and out_last is asserted only on the second byte.
- Multi-byte values:
  - 624485 -> 0xE5, 0x8E, 0x26.
  - -123456 -> 0xC0, 0xBB, 0x78.
- Extremes at N=64:
  - 0x8000000000000000 -> nine bytes of 0x80 then 0x7F (idx 0..9).
  - 0x7FFFFFFFFFFFFFFF -> nine bytes of 0xFF then 0x00.
- Handshakes:
  - Random out_ready stalls: the byte holds stable while stalled.
  - in_valid held continuously with values 1, -1, 300: stream 0x01, 0x7F, 0xAC, 0x02 with no idle cycle between values.
  - in_ready is asserted only in IDLE or on a last-byte handshake.
- Reset: assert rst after the 2nd byte of 624485 has been handshaken.
  - Next cycle: out_valid=0, in_ready=1, out_idx=0.
  - Encoding 5 afterwards -> 0x05 only.
